// File: rtl/async_fifo_unpacker.sv
// async_fifo_unpacker
//   Read-side consumer for async_fifo, running in the FIFO read clock domain.
//   Pops FIFO_WIDTH-bit words from the first-word-fall-through read port and
//   serializes each word into RATIO = FIFO_WIDTH/OUT_WIDTH beats on a
//   valid/ready stream. Also keeps a wrapping count of popped words and
//   supports a synchronous flush of the word being serialized.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing held; pop as soon as the FIFO shows a word
//   ST_SHIFT | a word is held; beats are presented one per handshake
//
// Ports
//   read_clock        in   clock, shared with the FIFO read side
//   reset_rsync       in   asynchronous active-high reset (read-domain synced)
//   fifo_empty        in   FIFO empty flag
//   fifo_read_data    in   FIFO head word, valid whenever fifo_empty=0
//   fifo_read_enable  out  combinational pop request to the FIFO
//   flush             in   drop the word currently being serialized
//   out_valid         out  output beat valid
//   out_ready         in   sink accepts the current beat
//   out_data          out  current beat
//   out_last          out  current beat is the final beat of its word
//   words_consumed    out  wrapping count of FIFO pops

module async_fifo_unpacker #(
    parameter int FIFO_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  read_clock,
    input  logic                  reset_rsync,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_enable,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic [15:0]           words_consumed
);

    localparam int RATIO = FIFO_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [FIFO_WIDTH-1:0]   r_hold_data;
    logic [IDX_W-1:0]        r_beat_idx;
    logic [15:0]             r_words_consumed;

    logic                    w_hold_valid;
    logic                    w_beat_done;
    logic                    w_last;
    logic                    w_pop;
    logic [IDX_W-1:0]        w_slice_sel;
    logic [OUT_WIDTH-1:0]    w_slices [RATIO];

    assign w_hold_valid = (r_state == ST_SHIFT);
    assign w_last       = w_hold_valid && (r_beat_idx == LAST_IDX);
    assign w_beat_done  = w_hold_valid && out_ready;

    // A new word may only be taken when nothing is held, or when the final
    // beat of the held word is leaving this cycle (zero-bubble refill).
    assign w_pop = !reset_rsync && !flush && !fifo_empty &&
                   (!w_hold_valid || (w_beat_done && w_last));

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign w_slices[g] = r_hold_data[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign w_slice_sel = MSB_FIRST ? (LAST_IDX - r_beat_idx) : r_beat_idx;

    assign fifo_read_enable = w_pop;
    assign out_valid        = w_hold_valid;
    assign out_last         = w_last;
    assign out_data         = w_slices[w_slice_sel];
    assign words_consumed   = r_words_consumed;

    always_ff @(posedge read_clock or posedge reset_rsync) begin
        if (reset_rsync) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (w_beat_done && w_last) begin
                    w_state_next = w_pop ? ST_SHIFT : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge read_clock or posedge reset_rsync) begin
        if (reset_rsync) begin
            r_hold_data      <= '0;
            r_beat_idx       <= '0;
            r_words_consumed <= '0;
        end else if (flush) begin
            // Held data is left in place; it is invisible once the FSM is idle.
            r_beat_idx <= '0;
        end else if (w_pop) begin
            r_hold_data      <= fifo_read_data;
            r_beat_idx       <= '0;
            r_words_consumed <= r_words_consumed + 16'd1;
        end else if (w_beat_done) begin
            r_beat_idx <= w_last ? '0 : r_beat_idx + 1'b1;
        end
    end

endmodule
